// File: rtl/mirror_meter_pkg.sv
// Shared types and constants for the mirror period meter and the laser synchronizer.
// Latency: none (declarations only).
// Backpressure: none.
package mirror_meter_pkg;

  localparam int unsigned PERIOD_W = 24;

  // Default edge-spacing limits, shared with the laser synchronizer top level
  localparam logic [PERIOD_W-1:0] MIN_PERIOD_DEF = 24'd100000;
  localparam logic [PERIOD_W-1:0] MAX_PERIOD_DEF = 24'd2000000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } state_e;

endpackage

// File: rtl/zc_deglitch.sv
// Resynchronises the raw comparator input and debounces it into a clean level plus rise strobe.
// Latency: SYNC_STAGES_P + DEBOUNCE_P cycles from a clean input change to filt_o/rise_o.
// Backpressure: none; rise_o is a single-cycle strobe.
module zc_deglitch #(
  parameter int unsigned SYNC_STAGES_P = 2,
  parameter int unsigned DEBOUNCE_P    = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic zc_raw_i,
  output logic filt_o,
  output logic rise_o
);

  localparam int unsigned     CNT_W    = (DEBOUNCE_P > 1) ? $clog2(DEBOUNCE_P) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_P - 1);

  logic [SYNC_STAGES_P-1:0] r_sync;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_filt;
  logic                     r_rise;
  logic                     w_sync;

  assign w_sync = r_sync[SYNC_STAGES_P-1];
  assign filt_o = r_filt;
  assign rise_o = r_rise;

  // Shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk_i) begin
    if (rst_i) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES_P-2:0], zc_raw_i};
  end

  // Count consecutive cycles the synchronised level disagrees with filt; any bounce restarts the count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (w_sync == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt  <= '0;
        r_filt <= w_sync;
        r_rise <= w_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mirror_period_meter.sv
// Conditions the mirror zero-cross into a clean zc_o pulse and measures/averages the mirror period.
// Latency: zc_o follows a clean zc_raw_i rise by SYNC_STAGES_P + DEBOUNCE_P + 1 cycles; all outputs registered.
// Backpressure: none; zc_o, freq_valid_o and timeout_o are single-cycle strobes, lock_o is a level.
module mirror_period_meter
  import mirror_meter_pkg::*;
#(
  parameter int unsigned         SYNC_STAGES_P = 2,
  parameter int unsigned         DEBOUNCE_P    = 16,
  parameter int unsigned         AVG_SHIFT_P   = 2,
  parameter logic [PERIOD_W-1:0] MIN_PERIOD_P  = MIN_PERIOD_DEF,
  parameter logic [PERIOD_W-1:0] MAX_PERIOD_P  = MAX_PERIOD_DEF,
  parameter int unsigned         TOL_SHIFT_P   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                zc_raw_i,
  input  logic                enable_i,
  output logic                zc_o,
  output logic [PERIOD_W-1:0] freq_o,
  output logic                freq_valid_o,
  output logic                lock_o,
  output logic                timeout_o
);

  // Period can reach MAX_PERIOD_P + 1, so it carries one extra bit
  localparam int unsigned        PER_W       = PERIOD_W + 1;
  localparam int unsigned        ACC_W       = PERIOD_W + AVG_SHIFT_P + 1;
  localparam int unsigned        SCNT_W      = AVG_SHIFT_P + 1;
  localparam logic [SCNT_W-1:0]  LAST_SAMPLE = SCNT_W'((1 << AVG_SHIFT_P) - 1);

  state_e              r_state, w_state_nxt;
  logic [PERIOD_W-1:0] r_pcnt;
  logic [PERIOD_W-1:0] r_freq;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    w_acc_sum;
  logic [SCNT_W-1:0]   r_scnt;
  logic                r_zc, r_fv, r_lock, r_to;
  logic                w_filt, w_rise, w_cand;
  logic [PER_W-1:0]    w_period, w_freq_ext, w_diff, w_tol;
  logic [PERIOD_W-1:0] w_avg;
  logic                w_accept, w_sample, w_restart, w_complete, w_timeout, w_clear;

  zc_deglitch #(
    .SYNC_STAGES_P (SYNC_STAGES_P),
    .DEBOUNCE_P    (DEBOUNCE_P)
  ) u_deglitch (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .zc_raw_i (zc_raw_i),
    .filt_o   (w_filt),
    .rise_o   (w_rise)
  );

  // A rise strobe only counts while the filtered level still reads high
  assign w_cand     = w_rise & w_filt;
  assign w_period   = PER_W'(r_pcnt) + PER_W'(1);
  assign w_freq_ext = PER_W'(r_freq);
  assign w_diff     = (w_period > w_freq_ext) ? (w_period - w_freq_ext) : (w_freq_ext - w_period);
  assign w_tol      = PER_W'(r_freq >> TOL_SHIFT_P);
  assign w_acc_sum  = r_acc + ACC_W'(w_period);
  assign w_avg      = PERIOD_W'(w_acc_sum >> AVG_SHIFT_P);
  assign w_clear    = !enable_i || (r_state == IDLE);

  assign zc_o         = r_zc;
  assign freq_o       = r_freq;
  assign freq_valid_o = r_fv;
  assign lock_o       = r_lock;
  assign timeout_o    = r_to;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and edge classification; enable low overrides everything, an accepted edge beats a timeout
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_restart   = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    if (!enable_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = ACQUIRE;
        ACQUIRE: begin
          if (w_cand) begin
            w_accept    = 1'b1;
            w_state_nxt = MEASURE;
          end
        end
        MEASURE, LOCKED: begin
          if (w_cand && (w_period >= PER_W'(MIN_PERIOD_P))) begin
            w_accept = 1'b1;
            if ((r_state == LOCKED) && (w_diff > w_tol)) begin
              w_restart   = 1'b1;
              w_state_nxt = MEASURE;
            end else begin
              w_sample = 1'b1;
              if (r_scnt == LAST_SAMPLE) begin
                w_complete  = 1'b1;
                w_state_nxt = LOCKED;
              end
            end
          end else if (r_pcnt == MAX_PERIOD_P) begin
            w_timeout   = 1'b1;
            w_state_nxt = ACQUIRE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Period counter restarts on each accepted edge and saturates at the timeout limit
  always_ff @(posedge clk_i) begin
    if (rst_i || w_clear || w_accept) r_pcnt <= '0;
    else if (r_pcnt != MAX_PERIOD_P)   r_pcnt <= r_pcnt + 1'b1;
  end

  // Block accumulator; a tolerance failure seeds a fresh block with the offending period
  always_ff @(posedge clk_i) begin
    if (rst_i || w_clear || w_timeout || w_complete) begin
      r_acc  <= '0;
      r_scnt <= '0;
    end else if (w_restart) begin
      r_acc  <= ACC_W'(w_period);
      r_scnt <= SCNT_W'(1);
    end else if (w_sample) begin
      r_acc  <= w_acc_sum;
      r_scnt <= r_scnt + 1'b1;
    end
  end

  // Registered outputs; freq_o only moves on block completion
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_zc   <= 1'b0;
      r_fv   <= 1'b0;
      r_lock <= 1'b0;
      r_to   <= 1'b0;
      r_freq <= '0;
    end else begin
      r_zc   <= w_accept;
      r_fv   <= w_complete;
      r_to   <= w_timeout;
      r_lock <= (w_state_nxt == LOCKED);
      if (w_complete) r_freq <= w_avg;
    end
  end

endmodule
